// File: rtl/pll_reconfig_pkg.sv
// Shared definitions for the sys_pll reconfiguration sequencer:
// FSM encodings, reconfig register map and the per-mode write list.
package pll_reconfig_pkg;

    localparam logic [2:0] ST_RST_HOLD  = 3'd0;
    localparam logic [2:0] ST_IDLE      = 3'd1;
    localparam logic [2:0] ST_WRITE     = 3'd2;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd3;
    localparam logic [2:0] ST_RETRY     = 3'd4;

    localparam logic [5:0] ADDR_MODE  = 6'h00;
    localparam logic [5:0] ADDR_START = 6'h02;
    localparam logic [5:0] ADDR_N     = 6'h03;
    localparam logic [5:0] ADDR_M     = 6'h04;
    localparam logic [5:0] ADDR_C     = 6'h05;

    localparam int         NUM_WRITES = 5;
    localparam logic [4:0] C_SEL      = 5'd2;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } mgmt_word_t;

    // Counter words are {high, low}; unknown modes fall back to mode 0.
    function automatic mgmt_word_t mode_word(
        input logic [7:0] mode,
        input logic [2:0] idx
    );
        logic [15:0] n_cnt;
        logic [15:0] m_cnt;
        logic [15:0] c_cnt;
        mgmt_word_t  w;
        case (mode)
            8'd1: begin
                n_cnt = 16'h0101;
                m_cnt = 16'h0908;
                c_cnt = 16'h0202;
            end
            8'd2: begin
                n_cnt = 16'h0302;
                m_cnt = 16'h1414;
                c_cnt = 16'h0504;
            end
            8'd3: begin
                n_cnt = 16'h0100;
                m_cnt = 16'h0B0A;
                c_cnt = 16'h0101;
            end
            default: begin
                n_cnt = 16'h0202;
                m_cnt = 16'h0C0C;
                c_cnt = 16'h0303;
            end
        endcase
        case (idx)
            3'd0:    w = '{addr: ADDR_MODE, data: 32'd0};
            3'd1:    w = '{addr: ADDR_N, data: {16'd0, n_cnt}};
            3'd2:    w = '{addr: ADDR_M, data: {16'd0, m_cnt}};
            3'd3:    w = '{addr: ADDR_C, data: {9'd0, C_SEL, 2'd0, c_cnt}};
            default: w = '{addr: ADDR_START, data: 32'd1};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/pll_reconfig_ctrl_debounce.sv
// Lock detector: 2-FF synchroniser for pll_locked plus a run-length
// counter that must see SETTLE_CYCLES consecutive synced-high cycles.
module pll_lock_debounce #(
    parameter int SETTLE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic lock_async_i,
    output logic lock_sync_o,
    output logic lock_stable_o
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !sync_q[1]) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(SETTLE_CYCLES)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], lock_async_i};
            cnt_q  <= cnt_d;
        end
    end

    assign lock_sync_o   = sync_q[1];
    assign lock_stable_o = (cnt_q == CW'(SETTLE_CYCLES));

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// PLL reconfiguration sequencer: rewrites N/M/C over Avalon-MM on a mode
// request, then holds the video-domain reset until lock is debounced.
module pll_reconfig_ctrl
    import pll_reconfig_pkg::*;
#(
    parameter int NUM_MODES     = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int LOCK_TIMEOUT  = 1048576,
    parameter int RETRY_MAX     = 3,
    localparam int MW           = $clog2(NUM_MODES)
) (
    input  logic          refclk,
    input  logic          rst,
    input  logic [MW-1:0] mode_req,
    input  logic          mode_valid,
    output logic          mode_ready,
    output logic [MW-1:0] cur_mode,
    output logic          busy,
    output logic          err,
    input  logic          pll_locked,
    output logic          pll_rst,
    output logic          vid_rst,
    output logic [5:0]    mgmt_address,
    output logic [31:0]   mgmt_writedata,
    output logic          mgmt_write,
    input  logic          mgmt_waitrequest
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int RW = $clog2(RETRY_MAX + 1);

    logic [2:0]    state_q, state_d;
    logic [SW-1:0] hold_q, hold_d;
    logic [2:0]    idx_q, idx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [MW-1:0] mode_q, mode_d;
    logic [MW-1:0] cur_q, cur_d;
    logic          err_q, err_d;
    logic          pll_rst_q, pll_rst_d;
    logic          vid_rst_q, vid_rst_d;
    logic          wr_q, wr_d;
    logic [5:0]    addr_q, addr_d;
    logic [31:0]   data_q, data_d;

    logic lock_sync;
    logic lock_stable;
    logic lock_lost;
    logic mode_ok;

    pll_lock_debounce #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_debounce (
        .clk_i        (refclk),
        .rst_i        (rst),
        .clr_i        (state_q != ST_WAIT_LOCK),
        .lock_async_i (pll_locked),
        .lock_sync_o  (lock_sync),
        .lock_stable_o(lock_stable)
    );

    // Lock loss only matters once the video domain has been released.
    assign lock_lost = !vid_rst_q && !lock_sync;
    assign mode_ok   = int'(mode_req) < NUM_MODES;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        idx_d     = idx_q;
        tmo_d     = '0;
        retry_d   = retry_q;
        mode_d    = mode_q;
        cur_d     = cur_q;
        err_d     = err_q;
        pll_rst_d = pll_rst_q;
        vid_rst_d = vid_rst_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        data_d    = data_q;
        case (state_q)
            ST_RST_HOLD, ST_RETRY: begin
                if (hold_q == SW'(SETTLE_CYCLES - 1)) begin
                    hold_d    = '0;
                    pll_rst_d = 1'b0;
                    if (state_q == ST_RETRY) begin
                        state_d          = ST_WRITE;
                        idx_d            = 3'd0;
                        wr_d             = 1'b1;
                        {addr_d, data_d} = mode_word(8'(mode_q), 3'd0);
                    end else begin
                        state_d = ST_WAIT_LOCK;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (lock_lost) begin
                    vid_rst_d = 1'b1;
                    state_d   = ST_WAIT_LOCK;
                end else if (mode_valid) begin
                    err_d = 1'b0;
                    if (!mode_ok) begin
                        err_d = 1'b1;
                    end else if (mode_req != cur_q || vid_rst_q) begin
                        mode_d           = mode_req;
                        vid_rst_d        = 1'b1;
                        retry_d          = '0;
                        idx_d            = 3'd0;
                        wr_d             = 1'b1;
                        {addr_d, data_d} = mode_word(8'(mode_req), 3'd0);
                        state_d          = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (!mgmt_waitrequest) begin
                    if (idx_q == 3'(NUM_WRITES - 1)) begin
                        wr_d    = 1'b0;
                        state_d = ST_WAIT_LOCK;
                    end else begin
                        idx_d            = idx_q + 3'd1;
                        {addr_d, data_d} = mode_word(8'(mode_q), idx_q + 3'd1);
                    end
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_stable) begin
                    cur_d     = mode_q;
                    vid_rst_d = 1'b0;
                    retry_d   = '0;
                    state_d   = ST_IDLE;
                end else if (tmo_q == TW'(LOCK_TIMEOUT)) begin
                    if (retry_q == RW'(RETRY_MAX)) begin
                        err_d   = 1'b1;
                        retry_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        retry_d   = retry_q + 1'b1;
                        pll_rst_d = 1'b1;
                        hold_d    = '0;
                        state_d   = ST_RETRY;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                state_d   = ST_RST_HOLD;
                hold_d    = '0;
                pll_rst_d = 1'b1;
                wr_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= ST_RST_HOLD;
            hold_q    <= '0;
            idx_q     <= '0;
            tmo_q     <= '0;
            retry_q   <= '0;
            mode_q    <= '0;
            cur_q     <= '0;
            err_q     <= 1'b0;
            pll_rst_q <= 1'b1;
            vid_rst_q <= 1'b1;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            retry_q   <= retry_d;
            mode_q    <= mode_d;
            cur_q     <= cur_d;
            err_q     <= err_d;
            pll_rst_q <= pll_rst_d;
            vid_rst_q <= vid_rst_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    assign mode_ready     = (state_q == ST_IDLE) && !lock_lost;
    assign busy           = (state_q != ST_IDLE);
    assign cur_mode       = cur_q;
    assign err            = err_q;
    assign pll_rst        = pll_rst_q;
    assign vid_rst        = vid_rst_q;
    assign mgmt_write     = wr_q;
    assign mgmt_address   = addr_q;
    assign mgmt_writedata = data_q;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Bench for pll_reconfig_ctrl: cycle-level behavioural model with
// directed scenarios, a randomised phase and a few literal pins.
module tb_pll_reconfig_ctrl;

    localparam int NM = 4;
    localparam int ST = 4;
    localparam int TO = 64;
    localparam int RM = 1;

    logic        refclk;
    logic        rst, mode_valid, pll_locked, mgmt_waitrequest;
    logic [1:0]  mode_req;
    logic        mode_ready, busy, err, pll_rst, vid_rst, mgmt_write;
    logic [1:0]  cur_mode;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;

    logic        mode_valid_b;
    logic [1:0]  mode_req_b;
    logic        mode_ready_b, busy_b, err_b, pll_rst_b, vid_rst_b, mgmt_write_b;
    logic [1:0]  cur_mode_b;
    logic [5:0]  mgmt_address_b;
    logic [31:0] mgmt_writedata_b;

    int checks = 0;
    int errors = 0;

    pll_reconfig_ctrl #(
        .NUM_MODES(NM), .SETTLE_CYCLES(ST), .LOCK_TIMEOUT(TO), .RETRY_MAX(RM)
    ) u_dut (
        .refclk(refclk), .rst(rst), .mode_req(mode_req), .mode_valid(mode_valid),
        .mode_ready(mode_ready), .cur_mode(cur_mode), .busy(busy), .err(err),
        .pll_locked(pll_locked), .pll_rst(pll_rst), .vid_rst(vid_rst),
        .mgmt_address(mgmt_address), .mgmt_writedata(mgmt_writedata),
        .mgmt_write(mgmt_write), .mgmt_waitrequest(mgmt_waitrequest)
    );

    // Three-entry table so an out-of-range request is expressible.
    pll_reconfig_ctrl #(
        .NUM_MODES(3), .SETTLE_CYCLES(ST), .LOCK_TIMEOUT(TO), .RETRY_MAX(RM)
    ) u_dut_b (
        .refclk(refclk), .rst(rst), .mode_req(mode_req_b), .mode_valid(mode_valid_b),
        .mode_ready(mode_ready_b), .cur_mode(cur_mode_b), .busy(busy_b), .err(err_b),
        .pll_locked(pll_locked), .pll_rst(pll_rst_b), .vid_rst(vid_rst_b),
        .mgmt_address(mgmt_address_b), .mgmt_writedata(mgmt_writedata_b),
        .mgmt_write(mgmt_write_b), .mgmt_waitrequest(mgmt_waitrequest)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 20)
                $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected write list, written out independently of the RTL table.
    function automatic logic [37:0] exp_word(input int mode, input int i);
        logic [31:0] nv, mv, cv;
        case (mode)
            1: begin nv = 32'h0000_0101; mv = 32'h0000_0908; cv = 32'h0008_0202; end
            2: begin nv = 32'h0000_0302; mv = 32'h0000_1414; cv = 32'h0008_0504; end
            3: begin nv = 32'h0000_0100; mv = 32'h0000_0B0A; cv = 32'h0008_0101; end
            default: begin nv = 32'h0000_0202; mv = 32'h0000_0C0C; cv = 32'h0008_0303; end
        endcase
        case (i)
            0: return {6'h00, 32'h0};
            1: return {6'h03, nv};
            2: return {6'h04, mv};
            3: return {6'h05, cv};
            default: return {6'h02, 32'h1};
        endcase
    endfunction

    typedef enum {P_HOLD, P_IDLE, P_WRITE, P_WAIT} phase_e;
    phase_e      m_phase;
    int          m_hold, m_age, m_run, m_tries, m_mode;
    bit          m_rewrite, m_live, m_s1, m_s2;
    logic [37:0] m_wq[$];
    bit          e_pll_rst, e_vid_rst, e_write, e_err;
    int          e_cur;
    logic [5:0]  e_addr;
    logic [31:0] e_data;

    task automatic start_writes();
        m_wq.delete();
        for (int i = 0; i < 5; i++) m_wq.push_back(exp_word(m_mode, i));
        e_write = 1'b1;
        {e_addr, e_data} = m_wq[0];
        m_phase = P_WRITE;
    endtask

    task automatic enter_wait();
        m_phase = P_WAIT;
        m_age = 0;
        m_run = 0;
    endtask

    task automatic model_step();
        bit s = m_s2;
        if (rst) begin
            m_live = 1'b1;
            m_phase = P_HOLD; m_hold = ST; m_rewrite = 1'b0;
            e_pll_rst = 1'b1; e_vid_rst = 1'b1; e_write = 1'b0; e_err = 1'b0;
            e_addr = '0; e_data = '0; e_cur = 0; m_mode = 0; m_tries = 0;
            m_wq.delete(); m_s1 = 1'b0; m_s2 = 1'b0;
            return;
        end
        case (m_phase)
            P_HOLD: begin
                m_hold--;
                if (m_hold == 0) begin
                    e_pll_rst = 1'b0;
                    if (m_rewrite) start_writes();
                    else enter_wait();
                end
            end
            P_IDLE: begin
                if (!e_vid_rst && !s) begin
                    e_vid_rst = 1'b1;
                    enter_wait();
                end else if (mode_valid) begin
                    e_err = 1'b0;
                    if (int'(mode_req) >= NM) e_err = 1'b1;
                    else if (int'(mode_req) != e_cur || e_vid_rst) begin
                        m_mode = int'(mode_req);
                        e_vid_rst = 1'b1;
                        m_tries = 0;
                        start_writes();
                    end
                end
            end
            P_WRITE: begin
                if (!mgmt_waitrequest) begin
                    void'(m_wq.pop_front());
                    if (m_wq.size() == 0) begin
                        e_write = 1'b0;
                        enter_wait();
                    end else begin
                        {e_addr, e_data} = m_wq[0];
                    end
                end
            end
            default: begin
                if (m_run >= ST) begin
                    e_cur = m_mode; e_vid_rst = 1'b0; m_tries = 0;
                    m_phase = P_IDLE;
                end else if (m_age == TO) begin
                    if (m_tries == RM) begin
                        e_err = 1'b1; m_tries = 0;
                        m_phase = P_IDLE;
                    end else begin
                        m_tries++; e_pll_rst = 1'b1;
                        m_hold = ST; m_rewrite = 1'b1;
                        m_phase = P_HOLD;
                    end
                end else begin
                    m_age++;
                    m_run = s ? m_run + 1 : 0;
                end
            end
        endcase
        m_s2 = m_s1;
        m_s1 = pll_locked;
    endtask

    initial begin
        m_live = 1'b0;
        forever begin
            @(posedge refclk);
            model_step();
        end
    end

    logic [37:0] wlog[$];
    int          wcyc[$];
    int          cyc = 0;
    int          stall_n = 0;
    int          prst_n = 0;

    initial begin
        forever begin
            @(negedge refclk);
            cyc++;
            if (m_live) begin
                chk("pll_rst", pll_rst, e_pll_rst);
                chk("vid_rst", vid_rst, e_vid_rst);
                chk("busy", busy, m_phase != P_IDLE);
                chk("mode_ready", mode_ready,
                    (m_phase == P_IDLE) && !(!e_vid_rst && !m_s2));
                chk("mgmt_write", mgmt_write, e_write);
                chk("mgmt_address", mgmt_address, e_addr);
                chk("mgmt_writedata", mgmt_writedata, e_data);
                chk("cur_mode", cur_mode, e_cur);
                chk("err", err, e_err);
            end
            if (!rst && mgmt_write === 1'b1 && !mgmt_waitrequest) begin
                wlog.push_back({mgmt_address, mgmt_writedata});
                wcyc.push_back(cyc);
            end
            if (mgmt_write === 1'b1 && mgmt_waitrequest && mgmt_address == 6'h03) stall_n++;
            if (pll_rst === 1'b1) prst_n++;
        end
    end

    bit rnd_wr = 1'b0;

    task automatic step();
        @(posedge refclk);
        #2;
        if (rnd_wr) mgmt_waitrequest = ($urandom_range(0, 2) == 0);
    endtask

    task automatic wait_ready(input int budget, input string name);
        int n = 0;
        while (mode_ready !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk(name, mode_ready, 1'b1);
    endtask

    task automatic request(input int m);
        mode_req = 2'(m);
        mode_valid = 1'b1;
        step();
        mode_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int m;
        int r;
        rst = 1'b1; mode_valid = 1'b0; mode_req = '0;
        pll_locked = 1'b0; mgmt_waitrequest = 1'b0;
        mode_valid_b = 1'b0; mode_req_b = '0;

        // Bring-up
        step();
        chk("rst_pll_rst", pll_rst, 1'b1);
        chk("rst_vid_rst", vid_rst, 1'b1);
        chk("rst_busy", busy, 1'b1);
        chk("rst_ready", mode_ready, 1'b0);
        chk("rst_write", mgmt_write, 1'b0);
        chk("rst_err", err, 1'b0);
        repeat (2) step();
        rst = 1'b0;
        n = 0;
        while (pll_rst === 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("pll_rst_width", n, 4);
        repeat (3) step();
        pll_locked = 1'b1;
        wait_ready(40, "t1_ready");
        chk("t1_cur_mode", cur_mode, 2'd0);
        chk("t1_vid_rst", vid_rst, 1'b0);

        // Out-of-range request on the three-mode instance
        chk("b_ready_pre", mode_ready_b, 1'b1);
        mode_req_b = 2'd3; mode_valid_b = 1'b1;
        step();
        mode_valid_b = 1'b0;
        chk("b_err_set", err_b, 1'b1);
        chk("b_ready_after", mode_ready_b, 1'b1);
        n = 0;
        repeat (4) begin
            if (mgmt_write_b !== 1'b0) n++;
            step();
        end
        chk("b_no_write", n, 0);
        mode_req_b = 2'd1; mode_valid_b = 1'b1;
        step();
        mode_valid_b = 1'b0;
        chk("b_err_clr", err_b, 1'b0);
        chk("b_write", mgmt_write_b, 1'b1);

        // Mode 2, no stalls, lock returns 10 cycles later
        wlog.delete(); wcyc.delete();
        request(2);
        pll_locked = 1'b0;
        repeat (10) step();
        pll_locked = 1'b1;
        wait_ready(60, "t2_ready");
        chk("t2_nwrites", wlog.size(), 5);
        if (wlog.size() == 5) begin
            chk("t2_addr0", wlog[0][37:32], 6'h00);
            chk("t2_addr1", wlog[1][37:32], 6'h03);
            chk("t2_addr2", wlog[2][37:32], 6'h04);
            chk("t2_addr3", wlog[3][37:32], 6'h05);
            chk("t2_addr4", wlog[4][37:32], 6'h02);
            chk("t2_n_data", wlog[1][31:0], 32'h0000_0302);
            chk("t2_c_data", wlog[3][31:0], 32'h0008_0504);
            chk("t2_consec", wcyc[4] - wcyc[0], 4);
        end
        chk("t2_cur_mode", cur_mode, 2'd2);
        chk("t2_busy", busy, 1'b0);

        // Mode 1 with the N write stalled three cycles
        wlog.delete(); stall_n = 0;
        request(1);
        step();
        mgmt_waitrequest = 1'b1;
        repeat (3) step();
        mgmt_waitrequest = 1'b0;
        wait_ready(60, "t3_ready");
        chk("t3_nwrites", wlog.size(), 5);
        chk("t3_stall", stall_n, 3);
        chk("t3_cur_mode", cur_mode, 2'd1);

        // Mode 3 never locks: one retry then error
        wlog.delete(); prst_n = 0;
        request(3);
        pll_locked = 1'b0;
        wait_ready(400, "t4_ready");
        chk("t4_err", err, 1'b1);
        chk("t4_vid_rst", vid_rst, 1'b1);
        chk("t4_cur_mode", cur_mode, 2'd1);
        chk("t4_nwrites", wlog.size(), 10);
        chk("t4_pll_rst_cycles", prst_n, 4);
        pll_locked = 1'b1;
        repeat (3) step();
        request(0);
        chk("t4_err_clr", err, 1'b0);
        wait_ready(60, "t4_relock");
        chk("t4_cur_mode0", cur_mode, 2'd0);

        // One-cycle lock glitch in IDLE
        wlog.delete();
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        n = 1;
        while (vid_rst !== 1'b1 && n < 6) begin
            step();
            n++;
        end
        chk("t5_vid_rst_lat", n, 3);
        wait_ready(30, "t5_ready");
        chk("t5_nwrites", wlog.size(), 0);
        chk("t5_vid_rst_rel", vid_rst, 1'b0);

        // Same-mode no-op, then reset during the third write
        wlog.delete();
        request(0);
        repeat (3) step();
        chk("t6_noop_writes", wlog.size(), 0);
        chk("t6_noop_busy", busy, 1'b0);
        request(2);
        repeat (2) step();
        chk("t6_third_addr", mgmt_address, 6'h04);
        rst = 1'b1;
        step();
        chk("t6_rst_write", mgmt_write, 1'b0);
        chk("t6_rst_pll", pll_rst, 1'b1);
        rst = 1'b0;
        wait_ready(60, "t6_ready");
        chk("t6_cur_mode", cur_mode, 2'd0);

        // Randomised requests, stalls and lock disturbances
        rnd_wr = 1'b1;
        for (int it = 0; it < 30; it++) begin
            m = $urandom_range(0, 3);
            r = $urandom_range(0, 7);
            wait_ready(800, "rnd_ready");
            if (r == 0) begin
                pll_locked = 1'b0;
                step();
                pll_locked = 1'b1;
            end else begin
                request(m);
                if (r == 1) begin
                    pll_locked = 1'b0;
                    repeat (150) step();
                    pll_locked = 1'b1;
                end else if (r < 5) begin
                    pll_locked = 1'b0;
                    repeat ($urandom_range(1, 8)) step();
                    pll_locked = 1'b1;
                end
            end
        end
        wait_ready(800, "rnd_final");
        rnd_wr = 1'b0;
        mgmt_waitrequest = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
